regbank_mp: RTL



---
 rtl/regbank_pkg.sv | 14 +
 rtl/regbank_scoreboard.sv | 47 ++++
 rtl/regbank_mp.sv | 93 +++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the multi-port register bank.
// Package regbank_pkg: zero-register index, SP defaults, address-valid check.
package regbank_pkg;

   localparam int unsigned ZERO_IDX     = 0;
   localparam int unsigned SP_IDX_DEF   = 16;
   localparam int unsigned SP_RESET_DEF = 1023;

   // An address names a real, writable entry: not the zero register, inside the bank.
   function automatic logic addr_valid(input int unsigned addr, input int unsigned num_regs);
      return (addr != ZERO_IDX) && (addr < num_regs);
   endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Per-register busy scoreboard for multi-cycle producers.
// An issue sets the destination bit, a write clears it; a same-cycle issue
// and write to one register leave it set, since the newer producer is still
// outstanding. Bit 0 never sets.
module regbank_scoreboard
   import regbank_pkg::*;
#(
   parameter int unsigned NUM_REGS = 17,
   parameter int unsigned AW       = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_addr,
   input  logic                we,
   input  logic [AW-1:0]       wr_addr,
   output logic [NUM_REGS-1:0] busy
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                iss_ok;
   logic                clr_ok;

   assign iss_ok = iss_valid && addr_valid(32'(iss_addr), NUM_REGS);
   assign clr_ok = we && addr_valid(32'(wr_addr), NUM_REGS);

   // Next busy vector: clear on write first, then set on issue so the set wins.
   always_comb begin
      // NOTE: every bit gets its hold value before the conditional updates, so no latch is inferred.
      busy_d = busy_q;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
         if (clr_ok && (wr_addr == AW'(r))) busy_d[r] = 1'b0;
         if (iss_ok && (iss_addr == AW'(r))) busy_d[r] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Busy state register; reset clears every outstanding producer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/regbank_mp.sv
// Parametrised multi-port register bank: RD_PORTS combinational read ports,
// one synchronous write port, hardwired zero register, SP entry with a reset
// value, busy scoreboard and a registered debug tap.
// Optional feature: define REGBANK_BYPASS_EN to forward the same-cycle write
// to all read ports and mask rd_busy for the register being written.
module regbank_mp
   import regbank_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 17,
   parameter int unsigned RD_PORTS = 2,
   parameter int unsigned AW       = 5,
   parameter int unsigned SP_IDX   = SP_IDX_DEF,
   parameter int unsigned SP_RESET = SP_RESET_DEF,
   parameter int unsigned DBG_IDX  = 11,
   parameter int unsigned DBG_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [RD_PORTS*AW-1:0]     rd_addr,
   output logic [RD_PORTS*DATA_W-1:0] rd_data,
   output logic [RD_PORTS-1:0]        rd_busy,
   input  logic                       we,
   input  logic [AW-1:0]              wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       iss_valid,
   input  logic [AW-1:0]              iss_addr,
   output logic [NUM_REGS-1:0]        busy,
   output logic [DBG_W-1:0]           dbg_out
);

   // Entry 0 is hardwired to zero and has no storage.
   logic [DATA_W-1:0] mem_q [1:NUM_REGS-1];
   logic [DBG_W-1:0]  dbg_q;
   logic              wr_ok;

   assign wr_ok = we && addr_valid(32'(wr_addr), NUM_REGS);

   regbank_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .we        (we),
      .wr_addr   (wr_addr),
      .busy      (busy)
   );

   // Storage array: async reset to zero except SP, then one write per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the bank is built from flops and must come out of reset with known SP, so every entry is reset.
         for (int unsigned r = 1; r < NUM_REGS; r++)
            mem_q[r] <= (r == SP_IDX) ? DATA_W'(SP_RESET) : '0;
      end else begin
         for (int unsigned r = 1; r < NUM_REGS; r++)
            // NOTE: state is updated with <= so every flop samples pre-edge values.
            if (wr_ok && (wr_addr == AW'(r))) mem_q[r] <= wr_data;
      end
   end

   // Read muxes: zero and out-of-range addresses return 0 and not busy.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned p = 0; p < RD_PORTS; p++) begin
         for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (rd_addr[p*AW +: AW] == AW'(r)) begin
               rd_data[p*DATA_W +: DATA_W] = mem_q[r];
               rd_busy[p]                  = busy[r];
            end
         end
`ifdef REGBANK_BYPASS_EN
         if (wr_ok && (rd_addr[p*AW +: AW] == wr_addr)) begin
            rd_data[p*DATA_W +: DATA_W] = wr_data;
            rd_busy[p]                  = 1'b0;
         end
`endif
      end
   end

   // Debug tap: capture the low bits of writes to DBG_IDX, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   dbg_q <= '0;
      else if (wr_ok && (wr_addr == AW'(DBG_IDX)))  dbg_q <= wr_data[DBG_W-1:0];
   end

   assign dbg_out = dbg_q;

endmodule
